bcd_down_counter: RTL
=====================

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 The module SHALL have parameter DIGITS, default 2, number of BCD digits (legal 1..4).
REQ-002 The module SHALL have port clk  input  1  rising-edge clock; the sole clock domain.
REQ-003 The module SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port load  input  1  load d into count and reload register.
REQ-005 The module SHALL have port d  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-006 The module SHALL have port en  input  1  count-down enable.
REQ-007 The module SHALL have port Q  output  4*DIGITS  current BCD count, registered.
REQ-008 The module SHALL have port zero  output  1  combinational, 1 when every digit of Q is 0.
REQ-009 The module SHALL have port done  output  1  registered terminal-count flag.
REQ-010 The module SHALL have port load_err  output  1  registered one-cycle flag for an out-of-range digit on load.

Function
REQ-011 Priority per edge SHALL be clear > load > en > hold.
REQ-012 With load=1, each digit of d SHALL be clamped to 9 if >9, then written to Q and the reload register on the same edge; done SHALL clear.
REQ-013 load_err SHALL be 1 for exactly the cycle after a load with any digit >9, else 0.
REQ-014 With en=1, load=0 and Q nonzero, Q SHALL decrement by one in decimal at each edge: digit 0 at 0 becomes 9 and borrows; the borrow ripples through every digit; no digit ever holds a value >9.
REQ-015 Decrement latency SHALL be one edge, with no combinational path from en to Q.
REQ-016 At an edge with en=1, load=0 and Q=0, the terminal event SHALL occur (see REQ-022/023).
REQ-017 With en=0 and load=0, Q, done and the reload register SHALL hold.
REQ-018 Simultaneous load and en SHALL load only; no decrement occurs that cycle.

Reset
REQ-019 An edge with clear=1 SHALL set Q=0, reload register=0, done=0 and load_err=0, overriding load and en.
REQ-020 Clear asserted mid-count SHALL take effect at the next edge, discarding the count in progress.
REQ-021 After clear is released, zero SHALL read 1 and the counter SHALL hold until load or en.

Configuration
REQ-022 Without BCD_DOWN_AUTO_RELOAD_EN, the terminal event SHALL leave Q at 0 (no wrap to 9..9) and set done=1; done SHALL stay set until load or clear.
REQ-023 With BCD_DOWN_AUTO_RELOAD_EN defined, the terminal event SHALL load Q from the reload register and pulse done for exactly one cycle; with a reload register of 0, done SHALL pulse on every enabled cycle.
REQ-024 In both builds, the reload register SHALL change only on load or clear.

Verification (DIGITS=2)
REQ-025 clear=1 for 2 edges with load=1, en=1 and d=8'h42 -> Q=8'h00, zero=1, done=0, load_err=0.
REQ-026 load d=8'h10, then en=1 for 3 edges -> Q=8'h09, 8'h08, 8'h07; borrow 10->09 correct.
REQ-027 load d=8'h3C -> Q=8'h39, load_err=1 for one cycle then 0.
REQ-028 load d=8'h02, en=1 for 5 edges, macro off -> Q=01,00,00,00,00; done=1 from the third edge and sticky; a later load d=8'h05 clears done.
REQ-029 Same stimulus, macro on -> Q=01,00,02,01,00; done high only in the cycle after the third edge.
REQ-030 load d=8'h55 with en=1 held, then clear=1 while Q=8'h53 with load=1 on the same edge -> Q=8'h00 next cycle, load ignored.

Source files
------------

// File: rtl/bcd_down_counter.sv
// Purpose : loadable multi-digit BCD down counter with terminal-count flag
//           and out-of-range load detection.
// Latency : one clock edge from load/en/clear to Q, done and load_err;
//           zero is combinational from the registered count.
// Backpressure: none; en and load are sampled every edge with priority
//           clear > load > en > hold.
//
// Ports:
//   clk      rising-edge clock, sole clock domain
//   clear    synchronous active-high reset (Q, reload register, done, load_err)
//   load     load d (clamped per digit to 9) into Q and the reload register
//   d        BCD load value, digit 0 in bits [3:0]
//   en       count-down enable
//   Q        current BCD count, registered
//   zero     1 when every digit of Q is 0
//   done     registered terminal-count flag
//   load_err registered one-cycle flag: the previous edge loaded a digit > 9
//
// Build option BCD_DOWN_AUTO_RELOAD_EN:
//   undefined : counting down from 0 leaves Q at 0 and sets a sticky done,
//               cleared only by load or clear.
//   defined   : counting down from 0 reloads Q from the reload register and
//               pulses done for one cycle.
//
// DIGITS is legal in the range 1..4.

module bcd_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] d,
  input  logic                en,
  output logic [4*DIGITS-1:0] Q,
  output logic                zero,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

`ifdef BCD_DOWN_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  logic [W-1:0] count_r;
  logic [W-1:0] reload_r;
  logic         done_r;
  logic         load_err_r;

  logic [W-1:0] d_clamped;
  logic         d_bad;
  logic [W-1:0] count_dec;
  logic         borrow;
  logic         count_is_zero;
  logic [W-1:0] terminal_value;

  // Clamp every load digit to 9 and note whether any digit needed clamping.
  always_comb begin
    d_clamped = '0;
    d_bad     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] > 4'd9) begin
        d_clamped[4*i +: 4] = 4'd9;
        d_bad               = 1'b1;
      end else begin
        d_clamped[4*i +: 4] = d[4*i +: 4];
      end
    end
  end

  // Decimal decrement of the registered count. Depends only on count_r, so
  // en merely selects this value at the flop input: no en-to-Q path exists.
  // A digit at 0 becomes 9 and passes the borrow upward; the first nonzero
  // digit absorbs it. Only used when count_r is nonzero.
  always_comb begin
    count_dec = '0;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_r[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_r[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end else begin
        count_dec[4*i +: 4] = count_r[4*i +: 4];
      end
    end
  end

  assign count_is_zero  = (count_r == '0);

  // Value taken on an enabled edge with the count already at zero: the
  // stored reload value in the auto-reload build, otherwise stay at zero.
  assign terminal_value = AUTO_RELOAD ? reload_r : '0;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_r    <= '0;
      reload_r   <= '0;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else if (load) begin
      // Load wins over en: no decrement on this edge.
      count_r    <= d_clamped;
      reload_r   <= d_clamped;
      done_r     <= 1'b0;
      load_err_r <= d_bad;
    end else begin
      load_err_r <= 1'b0;
      if (en) begin
        if (count_is_zero) begin
          count_r <= terminal_value;
          done_r  <= 1'b1;
        end else begin
          count_r <= count_dec;
          // Auto-reload done is a single-cycle pulse; the plain build keeps
          // done sticky until load or clear.
          if (AUTO_RELOAD) begin
            done_r <= 1'b0;
          end
        end
      end else if (AUTO_RELOAD) begin
        done_r <= 1'b0;
      end
    end
  end

  assign Q        = count_r;
  assign zero     = count_is_zero;
  assign done     = done_r;
  assign load_err = load_err_r;

endmodule
